// File: rtl/math_pkg.sv
// Shared encodings for the sequential calculator ALU: operation codes and
// controller states.
package math_pkg;

  localparam int unsigned OP_W = 2;
  localparam int unsigned ST_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_ITER = 2'b10,
    ST_FIN  = 2'b11
  } state_e;

endpackage : math_pkg

// File: rtl/math_adder_w.sv
// WIDTH-bit combinational adder with carry-in and carry-out; the single adder
// shared by every ALU operation.
module math_adder_w #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH:0]   sum_c
);

  assign sum_c = {1'b0, a_i} + {1'b0, b_i} + (WIDTH+1)'(cin_i);

endmodule : math_adder_w

// File: rtl/math_alu_seq.sv
// Multi-cycle unsigned ALU: single-cycle ADD/SUB, shift-add MUL and restoring
// DIV, one adder shared by all operations, start/done handshake.
module math_alu_seq
  import math_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned RES_W = 2 * WIDTH;

  state_e             state_q,  state_d;
  op_e                op_q,     op_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   opa_q,    opa_d;
  logic [WIDTH-1:0]   opb_q,    opb_d;
  logic               cin_q,    cin_d;
  logic [RES_W-1:0]   acc_q,    acc_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               err_q,    err_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;

  logic [WIDTH-1:0]   add_a_c;
  logic [WIDTH-1:0]   add_b_c;
  logic               add_cin_c;
  logic [WIDTH:0]     sum_c;
  logic [WIDTH-1:0]   div_shift_c;
  logic               div_ok_c;

  math_adder_w #(.WIDTH(WIDTH)) u_adder (
    .a_i   (add_a_c),
    .b_i   (add_b_c),
    .cin_i (add_cin_c),
    .sum_c (sum_c)
  );

  // Remainder shifted left by one with the next dividend bit; its MSB is
  // acc_q[RES_W-1] and is folded into the trial-subtract outcome below.
  assign div_shift_c = {acc_q[RES_W-2:WIDTH], acc_q[WIDTH-1]};
  assign div_ok_c    = acc_q[RES_W-1] | sum_c[WIDTH];

  // Adder operand steering per operation
  always_comb begin
    add_a_c   = opa_q;
    add_b_c   = opb_q;
    add_cin_c = cin_q;
    case (op_q)
      OP_SUB: begin
        add_b_c   = ~opb_q;
        add_cin_c = ~cin_q;
      end
      OP_MUL: begin
        add_a_c   = acc_q[RES_W-1:WIDTH];
        add_b_c   = acc_q[0] ? opa_q : '0;
        add_cin_c = 1'b0;
      end
      OP_DIV: begin
        add_a_c   = div_shift_c;
        add_b_c   = ~opb_q;
        add_cin_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cin_d    = cin_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op_e'(op);
          opa_d = a;
          opb_d = b;
          cin_d = cin;
          cnt_d = '0;
          if (op_e'(op) == OP_MUL) begin
            acc_d   = {{WIDTH{1'b0}}, b};
            state_d = ST_ITER;
          end else if (op_e'(op) == OP_DIV && b != '0) begin
            acc_d   = {{WIDTH{1'b0}}, a};
            state_d = ST_ITER;
          end else begin
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        state_d = ST_FIN;
        err_d   = 1'b0;
        case (op_q)
          OP_ADD:  result_d = RES_W'(sum_c);
          // carry-out of a + ~b + ~cin is the inverse of the borrow
          OP_SUB:  result_d = RES_W'({~sum_c[WIDTH], sum_c[WIDTH-1:0]});
          OP_DIV: begin
            result_d = {opa_q, {WIDTH{1'b1}}};
            err_d    = 1'b1;
          end
          default: ;
        endcase
      end

      ST_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_MUL) begin
          acc_d = {sum_c, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {(div_ok_c ? sum_c[WIDTH-1:0] : div_shift_c),
                   acc_q[WIDTH-2:0], div_ok_c};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = ST_FIN;
          result_d = acc_d;
          err_d    = 1'b0;
        end
      end

      ST_FIN: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_CALC) || (state_d == ST_ITER);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cin_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cin_q    <= cin_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule : math_alu_seq
